ttt_auto_player: RTL and testbench

Automatic opponent for the tic-tac-toe game core: the move-producing end of the player/board interface. It samples the nine board cells and the win flag when the controller grants its turn. It then scans the eight winning lines over successive cycles with a fixed priority: own win, block, centre, corner, side. It emits one 1..9 position code with a single-cycle strobe, which drives the game core's O-player position input in place of a human.

---
 rtl/ttt_pkg.sv | 44 ++++
 rtl/ttt_auto_player_if.sv | 20 ++
 rtl/ttt_line_eval.sv | 29 ++
 rtl/ttt_auto_player.sv | 138 +++++++++++++
 tb/tb_ttt_auto_player.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared cell codes, FSM states and scan tables for the auto player
package ttt_pkg;

  localparam logic [1:0] EMPTY    = 2'b00;
  localparam logic [1:0] MARK_X   = 2'b01;
  localparam logic [1:0] MARK_O   = 2'b10;
  localparam logic [1:0] MY_MARK  = MARK_O;
  localparam logic [1:0] OPP_MARK = MARK_X;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WIN   = 3'd1,
    BLOCK = 3'd2,
    PREF  = 3'd3,
    EMIT  = 3'd4,
    WAIT  = 3'd5
  } state_e;

  localparam logic [0:7][0:2][3:0] LINES = '{
    '{4'd1, 4'd2, 4'd3},
    '{4'd4, 4'd5, 4'd6},
    '{4'd7, 4'd8, 4'd9},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd3, 4'd6, 4'd9},
    '{4'd1, 4'd5, 4'd9},
    '{4'd3, 4'd5, 4'd7}
  };

  localparam logic [0:8][3:0] PREF_ORDER = '{
    4'd5, 4'd1, 4'd3, 4'd7, 4'd9, 4'd2, 4'd4, 4'd6, 4'd8
  };

  // Board is packed with cell 1 at index 0; out-of-range positions read as blocked.
  function automatic logic [1:0] cell_at(input logic [8:0][1:0] b, input logic [3:0] p);
    logic [1:0] c;
    c = 2'b11;
    for (int i = 0; i < 9; i++) begin
      if (p == 4'(i + 1)) c = b[i];
    end
    return c;
  endfunction

endpackage

// File: rtl/ttt_auto_player_if.sv
// rtl/ttt_auto_player_if.sv - board/turn inputs and move outputs between game core and auto player
interface ttt_auto_player_if;
  logic       turn;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic [1:0] win;
  logic [3:0] pos_play0;
  logic       move_valid;
  logic       no_move;
  logic       busy;

  modport master (
    output turn, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, win,
    input  pos_play0, move_valid, no_move, busy
  );

  modport slave (
    input  turn, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, win,
    output pos_play0, move_valid, no_move, busy
  );
endinterface

// File: rtl/ttt_line_eval.sv
// rtl/ttt_line_eval.sv - one winning line: two of the target mark plus one empty cell is a hit
import ttt_pkg::*;

module ttt_line_eval (
  input  logic [1:0] cell_a,
  input  logic [1:0] cell_b,
  input  logic [1:0] cell_c,
  input  logic [3:0] pos_a,
  input  logic [3:0] pos_b,
  input  logic [3:0] pos_c,
  input  logic [1:0] mark,
  output logic       hit,
  output logic [3:0] empty_pos
);

  logic [1:0] n_mark;
  logic [1:0] n_empty;

  always_comb begin
    n_mark  = {1'b0, cell_a == mark} + {1'b0, cell_b == mark} + {1'b0, cell_c == mark};
    n_empty = {1'b0, cell_a == EMPTY} + {1'b0, cell_b == EMPTY} + {1'b0, cell_c == EMPTY};
    hit     = (n_mark == 2'd2) && (n_empty == 2'd1);
    if (cell_a == EMPTY)      empty_pos = pos_a;
    else if (cell_b == EMPTY) empty_pos = pos_b;
    else if (cell_c == EMPTY) empty_pos = pos_c;
    else                      empty_pos = 4'd0;
  end

endmodule

// File: rtl/ttt_auto_player.sv
// rtl/ttt_auto_player.sv - automatic O player: snapshot board, scan win/block lines, then preference order
import ttt_pkg::*;

module ttt_auto_player (
  input  logic               clk,
  input  logic               rst,
  ttt_auto_player_if.slave   bus
);

  state_e           state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [8:0][1:0]  snap_q, snap_d;
  logic [3:0]       move_q, move_d;
  logic             found_q, found_d;
  logic [3:0]       pos_play0_q, pos_play0_d;
  logic             move_valid_q, move_valid_d;
  logic             no_move_q, no_move_d;
  logic             busy_q, busy_d;

  logic [1:0]       scan_mark;
  logic             line_hit;
  logic [3:0]       line_pos;
  logic             pref_hit;
  logic [3:0]       pref_pos;

  // One evaluator serves both scans; only the target mark changes.
  assign scan_mark = (state_q == BLOCK) ? OPP_MARK : MY_MARK;

  ttt_line_eval u_line_eval (
    .cell_a    (cell_at(snap_q, LINES[k_q][0])),
    .cell_b    (cell_at(snap_q, LINES[k_q][1])),
    .cell_c    (cell_at(snap_q, LINES[k_q][2])),
    .pos_a     (LINES[k_q][0]),
    .pos_b     (LINES[k_q][1]),
    .pos_c     (LINES[k_q][2]),
    .mark      (scan_mark),
    .hit       (line_hit),
    .empty_pos (line_pos)
  );

  // Walk the preference list backwards so the earliest empty entry wins.
  always_comb begin
    pref_hit = 1'b0;
    pref_pos = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (cell_at(snap_q, PREF_ORDER[i]) == EMPTY) begin
        pref_hit = 1'b1;
        pref_pos = PREF_ORDER[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    snap_d  = snap_q;
    move_d  = move_q;
    found_d = found_q;

    case (state_q)
      IDLE: begin
        if (bus.turn) begin
          snap_d  = {bus.pos9, bus.pos8, bus.pos7, bus.pos6, bus.pos5,
                     bus.pos4, bus.pos3, bus.pos2, bus.pos1};
          k_d     = 3'd0;
          move_d  = 4'd0;
          found_d = 1'b0;
          state_d = (bus.win != 2'b00) ? EMIT : WIN;
        end
      end
      WIN, BLOCK: begin
        if (!bus.turn) begin
          state_d = IDLE;
          k_d     = 3'd0;
        end else if (line_hit) begin
          move_d  = line_pos;
          found_d = 1'b1;
          state_d = EMIT;
          k_d     = 3'd0;
        end else if (k_q == 3'd7) begin
          state_d = (state_q == WIN) ? BLOCK : PREF;
          k_d     = 3'd0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      PREF: begin
        if (!bus.turn) begin
          state_d = IDLE;
        end else begin
          move_d  = pref_pos;
          found_d = pref_hit;
          state_d = EMIT;
        end
      end
      EMIT: state_d = WAIT;
      WAIT: begin
        if (!bus.turn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    move_valid_d = (state_d == EMIT) && found_d;
    no_move_d    = (state_d == EMIT) && !found_d;
    pos_play0_d  = ((state_d == EMIT || state_d == WAIT) && found_d) ? move_d : 4'd0;
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      k_q          <= 3'd0;
      snap_q       <= '0;
      move_q       <= 4'd0;
      found_q      <= 1'b0;
      pos_play0_q  <= 4'd0;
      move_valid_q <= 1'b0;
      no_move_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      snap_q       <= snap_d;
      move_q       <= move_d;
      found_q      <= found_d;
      pos_play0_q  <= pos_play0_d;
      move_valid_q <= move_valid_d;
      no_move_q    <= no_move_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.pos_play0  = pos_play0_q;
  assign bus.move_valid = move_valid_q;
  assign bus.no_move    = no_move_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ttt_auto_player.sv
// tb/tb_ttt_auto_player.sv - self-checking bench for ttt_auto_player against a rule-level move model
module tb_ttt_auto_player;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [1:0] brd [1:9];
  int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                       '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
  int pref  [9]    = '{5,1,3,7,9,2,4,6,8};

  ttt_auto_player_if bus ();

  ttt_auto_player dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic apply_board();
    bus.pos1 = brd[1]; bus.pos2 = brd[2]; bus.pos3 = brd[3];
    bus.pos4 = brd[4]; bus.pos5 = brd[5]; bus.pos6 = brd[6];
    bus.pos7 = brd[7]; bus.pos8 = brd[8]; bus.pos9 = brd[9];
  endtask

  task automatic clear_board();
    for (int i = 1; i <= 9; i++) brd[i] = 2'b00;
  endtask

  // Request edge T is the posedge this task returns after.
  task automatic start_req(input logic [1:0] w);
    @(negedge clk);
    apply_board();
    bus.win  = w;
    bus.turn = 1'b1;
    @(posedge clk);
  endtask

  task automatic observe(input int n, output int first_j, output int n_strobe,
                         output logic [3:0] spos, output logic snm, output logic busy1);
    first_j = 0; n_strobe = 0; spos = 4'hf; snm = 1'b0; busy1 = 1'b0;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      if (j == 1) busy1 = bus.busy;
      if (bus.move_valid || bus.no_move) begin
        n_strobe++;
        if (first_j == 0) begin
          first_j = j;
          spos    = bus.pos_play0;
          snm     = bus.no_move;
        end
      end
    end
  endtask

  task automatic end_req();
    @(negedge clk);
    bus.turn = 1'b0;
    bus.win  = 2'b00;
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic int find_two(input logic [1:0] m);
    for (int k = 0; k < 8; k++) begin
      int nm = 0, ne = 0, ep = 0;
      for (int c = 0; c < 3; c++) begin
        if (brd[lines[k][c]] == m) nm++;
        if (brd[lines[k][c]] == 2'b00) begin ne++; ep = lines[k][c]; end
      end
      if (nm == 2 && ne == 1) return k * 16 + ep;
    end
    return -1;
  endfunction

  task automatic predict(output int lat, output logic [3:0] p, output logic nm);
    int r;
    r = find_two(2'b10);
    if (r >= 0) begin lat = 2 + r / 16; p = 4'(r % 16); nm = 1'b0; return; end
    r = find_two(2'b01);
    if (r >= 0) begin lat = 10 + r / 16; p = 4'(r % 16); nm = 1'b0; return; end
    lat = 18; p = 4'd0; nm = 1'b1;
    for (int i = 8; i >= 0; i--) begin
      if (brd[pref[i]] == 2'b00) begin p = 4'(pref[i]); nm = 1'b0; end
    end
  endtask

  task automatic test_reset();
    bus.turn = 1'b0; bus.win = 2'b00; clear_board(); apply_board();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.pos_play0 !== 4'd0) begin failures++; $display("FAIL reset_pos got=%0d exp=0", bus.pos_play0); end
    checks++; if (bus.move_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.move_valid); end
    checks++; if (bus.no_move !== 1'b0) begin failures++; $display("FAIL reset_nomove got=%b exp=0", bus.no_move); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_priority();
    int fj, ns; logic [3:0] sp; logic snm, b1;
    clear_board(); brd[1] = 2'b01; brd[2] = 2'b01; brd[4] = 2'b10; brd[5] = 2'b10;
    start_req(2'b00);
    observe(25, fj, ns, sp, snm, b1);
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL prio_busy got=%b exp=1", b1); end
    checks++; if (fj != 3) begin failures++; $display("FAIL prio_latency got=%0d exp=3", fj); end
    checks++; if (sp !== 4'd6 || snm !== 1'b0) begin failures++; $display("FAIL prio_pos got=%0d nm=%b exp=6 nm=0", sp, snm); end
    checks++; if (ns != 1) begin failures++; $display("FAIL prio_strobes got=%0d exp=1", ns); end
    checks++; if (bus.pos_play0 !== 4'd6) begin failures++; $display("FAIL prio_hold got=%0d exp=6", bus.pos_play0); end
    end_req();
    checks++; if (bus.pos_play0 !== 4'd0 || bus.busy !== 1'b0) begin failures++; $display("FAIL prio_release pos=%0d busy=%b exp=0/0", bus.pos_play0, bus.busy); end
  endtask

  task automatic test_block();
    int fj, ns; logic [3:0] sp; logic snm, b1;
    clear_board(); brd[1] = 2'b01; brd[2] = 2'b01; brd[5] = 2'b10;
    start_req(2'b00);
    observe(25, fj, ns, sp, snm, b1);
    checks++; if (fj != 10 || sp !== 4'd3 || snm !== 1'b0) begin failures++; $display("FAIL block got=T+%0d pos=%0d nm=%b exp=T+10 pos=3 nm=0", fj, sp, snm); end
    end_req();
  endtask

  task automatic test_pref();
    int fj, ns; logic [3:0] sp; logic snm, b1;
    clear_board();
    start_req(2'b00);
    observe(25, fj, ns, sp, snm, b1);
    checks++; if (fj != 18 || sp !== 4'd5 || snm !== 1'b0) begin failures++; $display("FAIL pref_centre got=T+%0d pos=%0d exp=T+18 pos=5", fj, sp); end
    end_req();
    brd[5] = 2'b01;
    start_req(2'b00);
    observe(25, fj, ns, sp, snm, b1);
    checks++; if (fj != 18 || sp !== 4'd1 || snm !== 1'b0) begin failures++; $display("FAIL pref_corner got=T+%0d pos=%0d exp=T+18 pos=1", fj, sp); end
    end_req();
  endtask

  task automatic test_full_board();
    int fj, ns; logic [3:0] sp; logic snm, b1;
    brd[1] = 2'b01; brd[2] = 2'b10; brd[3] = 2'b01;
    brd[4] = 2'b01; brd[5] = 2'b10; brd[6] = 2'b10;
    brd[7] = 2'b10; brd[8] = 2'b01; brd[9] = 2'b11;
    start_req(2'b00);
    observe(25, fj, ns, sp, snm, b1);
    checks++; if (fj != 18 || snm !== 1'b1 || sp !== 4'd0) begin failures++; $display("FAIL full_board got=T+%0d nm=%b pos=%0d exp=T+18 nm=1 pos=0", fj, snm, sp); end
    end_req();
  endtask

  task automatic test_win_flag();
    int fj, ns; logic [3:0] sp; logic snm, b1;
    clear_board();
    start_req(2'b01);
    observe(10, fj, ns, sp, snm, b1);
    checks++; if (fj != 1 || snm !== 1'b1 || sp !== 4'd0) begin failures++; $display("FAIL win_flag got=T+%0d nm=%b pos=%0d exp=T+1 nm=1 pos=0", fj, snm, sp); end
    checks++; if (ns != 1) begin failures++; $display("FAIL win_flag_strobes got=%0d exp=1", ns); end
    end_req();
  endtask

  task automatic test_hold_turn();
    int fj, ns; logic [3:0] sp; logic snm, b1;
    clear_board(); brd[3] = 2'b10; brd[7] = 2'b10;
    start_req(2'b00);
    observe(60, fj, ns, sp, snm, b1);
    checks++; if (ns != 1 || sp !== 4'd5 || fj != 9) begin failures++; $display("FAIL hold_turn strobes=%0d pos=%0d at=T+%0d exp=1 pos=5 T+9", ns, sp, fj); end
    end_req();
  endtask

  task automatic test_abort();
    int ns = 0; int bad_pos = 0; logic busy6 = 1'b1;
    clear_board();
    start_req(2'b00);
    for (int j = 1; j <= 25; j++) begin
      @(negedge clk);
      if (bus.move_valid || bus.no_move) ns++;
      if (bus.pos_play0 !== 4'd0) bad_pos++;
      if (j == 6) busy6 = bus.busy;
      if (j == 4) bus.turn = 1'b0;
    end
    checks++; if (ns != 0 || bad_pos != 0) begin failures++; $display("FAIL abort_strobe strobes=%0d nonzero_pos=%0d exp=0/0", ns, bad_pos); end
    checks++; if (busy6 !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy6); end
  endtask

  task automatic test_reset_mid();
    int fj, ns; logic [3:0] sp; logic snm, b1;
    clear_board();
    start_req(2'b00);
    repeat (3) @(negedge clk);
    rst = 1'b0; bus.turn = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.pos_play0 !== 4'd0 || bus.move_valid !== 1'b0 || bus.no_move !== 1'b0) begin
      failures++; $display("FAIL reset_mid busy=%b pos=%0d mv=%b nm=%b exp all 0", bus.busy, bus.pos_play0, bus.move_valid, bus.no_move);
    end
    @(negedge clk);
    rst = 1'b1;
    observe(20, fj, ns, sp, snm, b1);
    checks++; if (ns != 0) begin failures++; $display("FAIL reset_mid_strobe got=%0d exp=0", ns); end
  endtask

  task automatic test_snapshot();
    int fj = 0; logic [3:0] sp = 4'hf;
    clear_board(); brd[1] = 2'b01; brd[2] = 2'b01; brd[5] = 2'b10;
    start_req(2'b00);
    for (int j = 1; j <= 25; j++) begin
      @(negedge clk);
      if (bus.move_valid && fj == 0) begin fj = j; sp = bus.pos_play0; end
      if (j == 2) begin
        bus.pos1 = 2'b10; bus.pos2 = 2'b10; bus.pos3 = 2'b00; bus.pos5 = 2'b01; bus.win = 2'b10;
      end
    end
    checks++; if (fj != 10 || sp !== 4'd3) begin failures++; $display("FAIL snapshot got=T+%0d pos=%0d exp=T+10 pos=3", fj, sp); end
    end_req();
  endtask

  task automatic test_random();
    int fj, ns, elat; logic [3:0] sp, ep; logic snm, enm, b1;
    for (int n = 0; n < 40; n++) begin
      for (int i = 1; i <= 9; i++) brd[i] = 2'($urandom_range(0, 3));
      predict(elat, ep, enm);
      start_req(2'b00);
      observe(21, fj, ns, sp, snm, b1);
      checks++;
      if (fj != elat || sp !== ep || snm !== enm || ns != 1) begin
        failures++;
        $display("FAIL random_%0d got=T+%0d pos=%0d nm=%b n=%0d exp=T+%0d pos=%0d nm=%b n=1",
                 n, fj, sp, snm, ns, elat, ep, enm);
      end
      end_req();
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_block();
    test_pref();
    test_full_board();
    test_win_flag();
    test_hold_turn();
    test_abort();
    test_reset_mid();
    test_snapshot();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
